// File: rtl/am_rectifier.sv
// AM demodulator front end: block-average DC offset tracker, offset removal,
// full-wave rectification and scaling to the 16-bit signed FIR input format.
module am_rectifier #(
    parameter int ADC_W    = 12,
    parameter int AVG_LOG2 = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADC_W-1:0] adc_in,
    input  logic             adc_valid,
    output logic [15:0]      rect_out,
    output logic             rect_valid,
    output logic [ADC_W-1:0] offset_out,
    output logic             offset_locked
);

    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int SHIFT = 15 - ADC_W;
    localparam logic [ADC_W-1:0] MIDSCALE = {1'b1, {(ADC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] HALF     = ACC_W'(1) << (AVG_LOG2 - 1);

    typedef enum logic {ACQUIRE, TRACK} state_t;

    state_t                    state_q, state_d;
    logic [ACC_W-1:0]          acc_q;
    logic [AVG_LOG2-1:0]       cnt_q;
    logic                      last;
    logic signed [ADC_W:0]     diff_p0;
    logic                      vld_p0;

    // Round-half-up mean of a completed window; the sum never exceeds ACC_W bits.
    function automatic logic [ADC_W-1:0] round_avg(input logic [ACC_W-1:0] sum);
        logic [ACC_W-1:0] r;
        r = (sum + HALF) >> AVG_LOG2;
        return r[ADC_W-1:0];
    endfunction

    // |d| always fits in ADC_W bits, so the result's sign bit stays clear.
    function automatic logic [15:0] rectify(input logic signed [ADC_W:0] d);
        logic [ADC_W:0] u;
        logic [ADC_W:0] m;
        logic [15:0]    w;
        u = d;
        m = u[ADC_W] ? (~u + {{ADC_W{1'b0}}, 1'b1}) : u;
        w = 16'(m[ADC_W-1:0]);
        return w << SHIFT;
    endfunction

    assign last          = (cnt_q == {AVG_LOG2{1'b1}});
    assign offset_locked = (state_q == TRACK);

    always_comb begin
        state_d = state_q;
        if (adc_valid && last) begin
            state_d = TRACK;
        end
    end

    // Stage p0: offset removal, using the offset in effect this cycle
    always_ff @(posedge clk) begin
        if (adc_valid) begin
            diff_p0 <= $signed({1'b0, adc_in}) - $signed({1'b0, offset_out});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACQUIRE;
            acc_q      <= '0;
            cnt_q      <= '0;
            offset_out <= MIDSCALE;
            vld_p0     <= 1'b0;
            rect_valid <= 1'b0;
            rect_out   <= '0;
        end else begin
            state_q    <= state_d;
            vld_p0     <= adc_valid;
            // Stage p1: rectify and scale; rect_out holds between samples
            rect_valid <= vld_p0;
            if (vld_p0) begin
                rect_out <= rectify(diff_p0);
            end
            if (adc_valid) begin
                if (last) begin
                    offset_out <= round_avg(acc_q + ACC_W'(adc_in));
                    acc_q      <= '0;
                    cnt_q      <= '0;
                end else begin
                    acc_q <= acc_q + ACC_W'(adc_in);
                    cnt_q <= cnt_q + AVG_LOG2'(1);
                end
            end
        end
    end

endmodule
